// File: rtl/scic_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for the SCIC accumulator core.
package scic_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SHL   = 4'h2;
  localparam logic [3:0] OP_SHR   = 4'h3;
  localparam logic [3:0] OP_LDI   = 4'h4;
  localparam logic [3:0] OP_LD    = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_BR    = 4'h8;
  localparam logic [3:0] OP_AND   = 4'h9;
  localparam logic [3:0] OP_SUB   = 4'hA;
  localparam logic [3:0] OP_BRZ   = 4'hB;
  localparam logic [3:0] OP_BRN   = 4'hC;
  localparam logic [3:0] OP_XOR   = 4'hD;
  localparam logic [3:0] OP_NOP_E = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // Opcodes whose EXEC phase goes out to memory (and so waits on mem_ready).
  function automatic logic is_mem_op(input logic [3:0] opcode);
    case (opcode)
      OP_ADD, OP_SHL, OP_SHR, OP_LD, OP_OR,
      OP_ST, OP_AND, OP_SUB, OP_XOR: is_mem_op = 1'b1;
      default:                       is_mem_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/scic_alu.sv
// Combinational accumulator ALU: computes the next AC value for arithmetic, logic and load opcodes.
module scic_alu
  import scic_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        i_opcode,
  input  logic [DATA_W-1:0] i_ac,
  input  logic [DATA_W-1:0] i_operand,
  output logic [DATA_W-1:0] o_result
);

  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

  logic w_big_shift;

  // Shifts of DATA_W or more are clamped to zero explicitly rather than trusting operator semantics.
  always_comb begin
    w_big_shift = (i_operand >= SHIFT_LIM);
    o_result    = i_ac;
    case (i_opcode)
      OP_ADD:         o_result = i_ac + i_operand;
      OP_SUB:         o_result = i_ac - i_operand;
      OP_SHL:         o_result = w_big_shift ? '0 : (i_ac << i_operand);
      OP_SHR:         o_result = w_big_shift ? '0 : (i_ac >> i_operand);
      OP_OR:          o_result = i_ac | i_operand;
      OP_AND:         o_result = i_ac & i_operand;
      OP_XOR:         o_result = i_ac ^ i_operand;
      OP_LD, OP_LDI:  o_result = i_operand;
      default:        o_result = i_ac;
    endcase
  end

endmodule

// File: rtl/scic_cpu_core.sv
// Second-generation SCIC accumulator CPU: Fetch/Execute over a shared memory with a req/ready handshake.
// Handshake: an access is offered while req=1 and completes on the first cycle mem_ready=1; mem_ready with req=0 is ignored.
module scic_cpu_core
  import scic_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] address,
  output logic              req,
  output logic              we,
  output logic              halted,
  output logic              ac_zero,
  output logic [1:0]        o_dbg_state
);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_ac;

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_opd;
  logic              w_mem_op;
  logic [DATA_W-1:0] w_alu_operand;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_fetch_done;
  logic              w_ac_load;
  logic              w_branch_taken;

  assign w_opcode      = r_ir[DATA_W-1 -: 4];
  assign w_opd         = r_ir[ADDR_W-1:0];
  assign w_mem_op      = is_mem_op(w_opcode);
  assign w_alu_operand = w_mem_op ? data_in : {{(DATA_W-ADDR_W){1'b0}}, w_opd};

  scic_alu #(.DATA_W(DATA_W)) u_alu (
    .i_opcode  (w_opcode),
    .i_ac      (r_ac),
    .i_operand (w_alu_operand),
    .o_result  (w_alu_result)
  );

  assign w_fetch_done   = (r_state == S_FETCH) && mem_ready;
  assign w_ac_load      = (r_state == S_EXEC) &&
                          ((w_mem_op && (w_opcode != OP_ST) && mem_ready) || (w_opcode == OP_LDI));
  assign w_branch_taken = (r_state == S_EXEC) &&
                          ((w_opcode == OP_BR) ||
                           ((w_opcode == OP_BRZ) && (r_ac == '0)) ||
                           ((w_opcode == OP_BRN) && r_ac[DATA_W-1]));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: if (mem_ready) w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_opcode == OP_HALT)         w_next_state = S_HALT;
        else if (!w_mem_op || mem_ready) w_next_state = S_FETCH;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Outputs depend on state/IR/PC only, so the memory never sees a combinational path from mem_ready.
  always_comb begin
    req     = 1'b0;
    we      = 1'b0;
    halted  = 1'b0;
    address = r_pc;
    case (r_state)
      S_FETCH: req = 1'b1;
      S_EXEC: begin
        address = w_opd;
        req     = w_mem_op;
        we      = (w_opcode == OP_ST);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_ac <= '0;
    end else begin
      if (w_fetch_done) begin
        r_ir <= data_in;
        r_pc <= r_pc + ADDR_W'(1);
      end else if (w_branch_taken) begin
        r_pc <= w_opd;
      end
      if (w_ac_load) r_ac <= w_alu_result;
    end
  end

  assign data_out    = r_ac;
  assign ac_zero     = (r_ac == '0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_scic_cpu_core.sv
// Bench for scic_cpu_core: a 32/16 instance and a 16/8 instance run the same programs from a shared loader.
module tb_scic_cpu_core;
  import scic_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT 32/16 ----------------
  logic [31:0] data_in, data_out;
  logic [15:0] address;
  logic        mem_ready, req, we, halted, ac_zero;
  logic [1:0]  dbg_state;
  logic [31:0] mem32 [0:65535];

  // ---------------- DUT 16/8 ----------------
  logic [15:0] d_in16, d_out16;
  logic [7:0]  addr16;
  logic        ready16, req16, we16, halted16, zero16;
  logic [1:0]  st16;
  logic [15:0] mem16 [0:255];

  // Memory model: combinational read, programmable wait states for the 32-bit instance.
  int   ready_delay = 0;
  int   wcnt;
  logic force_ready = 1'b0;
  int   wr_cnt;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  assign data_in   = mem32[address];
  assign mem_ready = force_ready | (req && (wcnt >= ready_delay));
  assign d_in16    = mem16[addr16];
  assign ready16   = req16;

  always @(posedge clock or posedge reset) begin
    if (reset)                 wcnt <= 0;
    else if (!req || mem_ready) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt  <= 0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (req && we && mem_ready) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= address;
      wr_data <= data_out;
    end
  end

  scic_cpu_core #(.DATA_W(32), .ADDR_W(16), .RESET_PC(16'h0010)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .mem_ready(mem_ready),
    .data_out(data_out), .address(address), .req(req), .we(we),
    .halted(halted), .ac_zero(ac_zero), .o_dbg_state(dbg_state)
  );

  scic_cpu_core #(.DATA_W(16), .ADDR_W(8), .RESET_PC(8'h10)) dut16 (
    .clock(clock), .reset(reset), .data_in(d_in16), .mem_ready(ready16),
    .data_out(d_out16), .address(addr16), .req(req16), .we(we16),
    .halted(halted16), .ac_zero(zero16), .o_dbg_state(st16)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem32[i]         = '0;
      mem32[65280 + i] = '0;
      mem16[i]         = '0;
    end
  endtask

  task automatic put_ins(input logic [15:0] a, input logic [3:0] op, input logic [15:0] opd);
    mem32[a]      = {op, 12'h000, opd};
    mem16[a[7:0]] = {op, 4'h0, opd[7:0]};
  endtask

  task automatic put_data(input logic [15:0] a, input logic [31:0] d32, input logic [15:0] d16);
    mem32[a]      = d32;
    mem16[a[7:0]] = d16;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_halt(input bit both, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (halted && (!both || halted16)) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
  endtask

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] ac0;
    logic [31:0] opnd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  initial begin
    bit ok;
    int we_cyc;
    bit bad;

    vecs[0]  = '{OP_ADD,   32'hFFFF_FFFF, 32'h1,    32'h0};
    vecs[1]  = '{OP_ADD,   32'h3,         32'h4,    32'h7};
    vecs[2]  = '{OP_SUB,   32'h5,         32'h7,    32'hFFFF_FFFE};
    vecs[3]  = '{OP_SUB,   32'hA,         32'hA,    32'h0};
    vecs[4]  = '{OP_SHL,   32'h1,         32'd40,   32'h0};
    vecs[5]  = '{OP_SHL,   32'h3,         32'd4,    32'h30};
    vecs[6]  = '{OP_SHL,   32'h1,         32'd31,   32'h8000_0000};
    vecs[7]  = '{OP_SHL,   32'h1,         32'd32,   32'h0};
    vecs[8]  = '{OP_SHR,   32'h8000_0000, 32'd31,   32'h1};
    vecs[9]  = '{OP_SHR,   32'hFFFF_FFFF, 32'd33,   32'h0};
    vecs[10] = '{OP_OR,    32'hF0,        32'h0F,   32'hFF};
    vecs[11] = '{OP_AND,   32'hFF,        32'h3C,   32'h3C};
    vecs[12] = '{OP_XOR,   32'hFF,        32'h0F,   32'hF0};
    vecs[13] = '{OP_LD,    32'h5,         32'h1234, 32'h1234};
    vecs[14] = '{OP_NOP_E, 32'hABCD,      32'h1234, 32'hABCD};

    // Reset state and first fetch from RESET_PC
    clear_mem();
    put_ins(16'h10, OP_LDI, 16'h23);
    put_ins(16'h11, OP_HALT, 16'h0);
    ready_delay = 0;
    do_reset();
    check("rst address",  32'(address), 32'h10);
    check("rst req",      32'(req), 32'h1);
    check("rst we",       32'(we), 32'h0);
    check("rst halted",   32'(halted), 32'h0);
    check("rst ac_zero",  32'(ac_zero), 32'h1);
    check("rst data_out", data_out, 32'h0);
    check("rst state",    32'(dbg_state), 32'(S_FETCH));
    check("rst16 address", 32'(addr16), 32'h10);
    check("rst16 req/we",  {30'h0, req16, we16}, 32'h2);
    check("rst16 zero",    32'(zero16), 32'h1);
    @(negedge clock);
    check("ldi exec state", 32'(dbg_state), 32'(S_EXEC));
    check("ldi exec address", 32'(address), 32'h23);
    check("ldi exec req", 32'(req), 32'h0);
    @(negedge clock);
    check("ldi result", data_out, 32'h23);
    check("ldi next pc", 32'(address), 32'h11);
    check("ldi16 result", 32'(d_out16), 32'h23);
    check("ldi16 state",  32'(st16), 32'(S_FETCH));

    // Table: LD 0x80; <op> 0x81; HALT, with varying wait states
    for (int i = 0; i < 15; i++) begin
      clear_mem();
      put_ins(16'h10, OP_LD, 16'h80);
      put_ins(16'h11, vecs[i].op, 16'h81);
      put_ins(16'h12, OP_HALT, 16'h0);
      put_data(16'h80, vecs[i].ac0, 16'h0);
      put_data(16'h81, vecs[i].opnd, 16'h0);
      ready_delay = i % 3;
      do_reset();
      wait_halt(1'b0, ok);
      check($sformatf("vec%0d halted", i), 32'(ok), 32'h1);
      check($sformatf("vec%0d ac", i), data_out, vecs[i].exp);
      check($sformatf("vec%0d ac_zero", i), 32'(ac_zero), 32'(vecs[i].exp == 32'h0));
    end
    ready_delay = 0;

    // LDI 5; SUB 7; BRN taken
    clear_mem();
    put_ins(16'h10, OP_LDI, 16'h5);
    put_ins(16'h11, OP_SUB, 16'h80);
    put_ins(16'h12, OP_BRN, 16'h20);
    put_ins(16'h13, OP_LDI, 16'h99);
    put_ins(16'h14, OP_HALT, 16'h0);
    put_ins(16'h20, OP_HALT, 16'h0);
    put_data(16'h80, 32'h7, 16'h7);
    do_reset();
    wait_halt(1'b1, ok);
    check("brn halted", 32'(ok), 32'h1);
    check("brn ac", data_out, 32'hFFFF_FFFE);
    check("brn pc", 32'(address), 32'h21);
    check("brn16 ac", 32'(d_out16), 32'hFFFE);
    check("brn16 pc", 32'(addr16), 32'h21);

    // BRZ taken then not taken
    clear_mem();
    put_ins(16'h10, OP_LDI, 16'h0);
    put_ins(16'h11, OP_BRZ, 16'h40);
    put_ins(16'h12, OP_HALT, 16'h0);
    put_ins(16'h40, OP_LDI, 16'h1);
    put_ins(16'h41, OP_BRZ, 16'h50);
    put_ins(16'h42, OP_HALT, 16'h0);
    put_ins(16'h50, OP_LDI, 16'h77);
    put_ins(16'h51, OP_HALT, 16'h0);
    do_reset();
    wait_halt(1'b1, ok);
    check("brz halted", 32'(ok), 32'h1);
    check("brz ac", data_out, 32'h1);
    check("brz pc", 32'(address), 32'h43);
    check("brz16 ac", 32'(d_out16), 32'h1);
    check("brz16 pc", 32'(addr16), 32'h43);

    // Branch to last address, PC wraps to 0
    clear_mem();
    put_ins(16'h10, OP_BR, 16'hFFFF);
    put_ins(16'hFFFF, OP_LDI, 16'h3);
    put_ins(16'h0000, OP_HALT, 16'h0);
    do_reset();
    wait_halt(1'b1, ok);
    check("wrap halted", 32'(ok), 32'h1);
    check("wrap ac", data_out, 32'h3);
    check("wrap pc", 32'(address), 32'h1);
    check("wrap16 pc", 32'(addr16), 32'h1);

    // ST with three wait states
    clear_mem();
    put_ins(16'h10, OP_LDI, 16'h5A);
    put_ins(16'h11, OP_ST, 16'h30);
    put_ins(16'h12, OP_HALT, 16'h0);
    ready_delay = 3;
    do_reset();
    we_cyc = 0;
    bad = 1'b0;
    for (int c = 0; c < 200 && !halted; c++) begin
      @(negedge clock);
      if (we) begin
        we_cyc++;
        if (address != 16'h30 || data_out != 32'h5A || !req) bad = 1'b1;
      end
    end
    check("st halted", 32'(halted), 32'h1);
    check("st we cycles", 32'(we_cyc), 32'd4);
    check("st we bus", 32'(bad), 32'h0);
    check("st writes", 32'(wr_cnt), 32'd1);
    check("st wr addr", 32'(wr_addr), 32'h30);
    check("st wr data", wr_data, 32'h5A);
    ready_delay = 0;

    // HALT freezes PC even with mem_ready asserted
    clear_mem();
    put_ins(16'h10, OP_HALT, 16'h0);
    do_reset();
    wait_halt(1'b0, ok);
    check("halt reached", 32'(ok), 32'h1);
    check("halt state", 32'(dbg_state), 32'(S_HALT));
    force_ready = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (address != 16'h11 || req || we || !halted) bad = 1'b1;
    end
    force_ready = 1'b0;
    check("halt frozen", 32'(bad), 32'h0);

    // Reset asserted while an LD is waiting on memory
    clear_mem();
    put_ins(16'h10, OP_LD, 16'h80);
    put_data(16'h80, 32'hDEAD_BEEF, 16'hBEEF);
    ready_delay = 10;
    do_reset();
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clock);
      if (dbg_state == S_EXEC) ok = 1'b1;
    end
    check("ld wait exec", 32'(ok), 32'h1);
    check("ld wait address", 32'(address), 32'h80);
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid rst state", 32'(dbg_state), 32'(S_FETCH));
    check("mid rst address", 32'(address), 32'h10);
    check("mid rst req/we", {30'h0, req, we}, 32'h2);
    check("mid rst ac", data_out, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    ready_delay = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
